// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing engine driving HS/VS/BLANK/CLK/RGB and popping a show-ahead pixel FIFO.
// Latency: HS/VS/BLANK/RGB are registered one cycle after the counter value they decode; fifo_rd is combinational.
// Backpressure: none, because timing never stalls. An empty FIFO in the active area gives a black pixel and sets sticky underflow.
// Optional feature: define VTG_FRAME_CNT_EN to add the o_frame_cnt output.
module video_timing_gen #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic        i_pixel_clk,
  input  logic        i_pixel_rst,
  input  logic [23:0] i_fifo_rdata,
  input  logic        i_fifo_empty,
  input  logic        i_fifo_almost_full,
  output logic        o_fifo_rd,
  output logic        o_vid_clk,
  output logic        o_vid_hs,
  output logic        o_vid_vs,
  output logic        o_vid_blank,
  output logic [23:0] o_vid_rgb,
  output logic        o_underflow
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0] o_frame_cnt
`endif
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  // Inclusive bounds, so no constant ever needs to hold HTOTAL itself.
  localparam logic [HW-1:0] H_LAST       = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LAST   = HW'(HDISP - 1);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(HDISP + HFP + HPULSE - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST   = VW'(VDISP - 1);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(VDISP + VFP + VPULSE - 1);

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic [23:0]   r_rgb;
  logic          r_underflow;

  logic w_h_last;
  logic w_v_last;
  logic w_frame_last;
  logic w_act;
  logic w_hs_on;
  logic w_vs_on;

  assign w_h_last     = (r_hcnt == H_LAST);
  assign w_v_last     = (r_vcnt == V_LAST);
  assign w_frame_last = w_h_last && w_v_last;
  assign w_act        = (r_hcnt <= H_ACT_LAST) && (r_vcnt <= V_ACT_LAST);
  assign w_hs_on      = (r_hcnt >= H_SYNC_FIRST) && (r_hcnt <= H_SYNC_LAST);
  assign w_vs_on      = (r_vcnt >= V_SYNC_FIRST) && (r_vcnt <= V_SYNC_LAST);

  // Pop the FIFO head for every active pixel once synced. Reset gates it at once.
  assign o_fifo_rd = (r_state == S_RUN) && w_act && !i_pixel_rst;

  assign o_vid_clk   = i_pixel_clk;
  assign o_vid_hs    = r_hs;
  assign o_vid_vs    = r_vs;
  assign o_vid_blank = r_blank;
  assign o_vid_rgb   = r_rgb;
  assign o_underflow = r_underflow;

  // Free-running raster position: hcnt every cycle, vcnt on each hcnt wrap
  always_ff @(posedge i_pixel_clk) begin
    if (i_pixel_rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // Sync FSM plus registered video outputs decoded from the current raster position
  always_ff @(posedge i_pixel_clk) begin
    if (i_pixel_rst) begin
      r_state     <= S_WAIT;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_blank     <= 1'b0;
      r_rgb       <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_hs    <= ~w_hs_on;
      r_vs    <= ~w_vs_on;
      r_blank <= w_act;
      r_rgb   <= '0;
      case (r_state)
        // Start on the last pixel of a frame, so the first pop lands on (0,0).
        S_WAIT: begin
          if (w_frame_last && i_fifo_almost_full) begin
            r_state <= S_RUN;
          end
        end
        // A missing pixel is shown black and never retried. Timing keeps going.
        S_RUN: begin
          if (w_act && !i_fifo_empty) begin
            r_rgb <= i_fifo_rdata;
          end
          if (w_act && i_fifo_empty) begin
            r_underflow <= 1'b1;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  assign o_frame_cnt = r_frame_cnt;

  // Count completed frames in either state; wraps naturally at 16 bits
  always_ff @(posedge i_pixel_clk) begin
    if (i_pixel_rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame_last) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`endif

endmodule
